// File: rtl/disp_cfg_pkg.sv
// ---------------------------------------------------------------------------
// disp_cfg_pkg
//
// Shared definitions for the display configuration sequencer:
//   - cfgAddr register map (which active setting a host write targets)
//   - values the active display settings take out of reset
//   - frame counter width used by the flash divider
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package disp_cfg_pkg;

    // Register map seen by the host on cfgAddr
    localparam logic [1:0] CFG_CHAR_RGB    = 2'd0;
    localparam logic [1:0] CFG_BK_RGB      = 2'd1;
    localparam logic [1:0] CFG_CHAR_SIZE   = 2'd2;
    localparam logic [1:0] CFG_CHAR_OFFSET = 2'd3;

    // Power-up look: white characters on black, unscaled, no offset
    localparam logic [8:0] CHAR_RGB_RESET    = 9'h1FF;
    localparam logic [8:0] BK_RGB_RESET      = 9'h000;
    localparam logic [3:0] CHAR_SIZE_RESET   = 4'd1;
    localparam logic [3:0] CHAR_OFFSET_RESET = 4'd0;

    // Wide enough for the largest legal FLASH_FRAMES (255)
    localparam int FRAME_CNT_W = 8;

    // IDLE accepts host writes; COMMIT is the single cycle in which
    // dirty shadow registers are copied into the active outputs
    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } seqState_t;

endpackage

// File: rtl/flash_divider.sv
// ---------------------------------------------------------------------------
// flash_divider
//
// Counts frames and toggles flashClk once every FLASH_FRAMES frames, giving
// the blink rate for flashing characters.
//
// Parameters:
//   FLASH_FRAMES  frames per flashClk half-period, 1..255
// Ports:
//   clock     in   sole clock
//   reset     in   synchronous, active-low reset
//   frameEnd  in   one-cycle pulse at the first blanked line of each frame
//   flashClk  out  blink enable, starts low after reset
// ---------------------------------------------------------------------------
module flash_divider
    import disp_cfg_pkg::*;
#(
    parameter int FLASH_FRAMES = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic frameEnd,
    output logic flashClk
);

    localparam logic [FRAME_CNT_W-1:0] LastCount = FRAME_CNT_W'(FLASH_FRAMES - 1);

    logic [FRAME_CNT_W-1:0] frameCnt;

    // Frame counter wraps after LastCount; the wrap is what flips flashClk,
    // so with FLASH_FRAMES = 1 the counter sits at zero and every frame toggles
    always_ff @(posedge clock) begin
        if (!reset) begin
            frameCnt <= '0;
            flashClk <= 1'b0;
        end else if (frameEnd) begin
            if (frameCnt == LastCount) begin
                frameCnt <= '0;
                flashClk <= ~flashClk;
            end else begin
                frameCnt <= frameCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// disp_cfg_sequencer
//
// Frame-synchronous configuration sequencer for the character display path.
// Host writes land in shadow registers and are copied into the active
// display settings only in the COMMIT cycle that follows frameEnd, so a
// frame is never drawn with a mix of old and new settings.
//
// Build option:
//   DISP_CFG_FLASH_EN  defined   -> flash_divider drives flashClk
//                      undefined -> flashClk tied high (always visible)
//
// Parameters:
//   FLASH_FRAMES  frames per flashClk half-period, 1..255
// Ports:
//   clock         in   sole clock
//   reset         in   synchronous, active-low reset
//   frameEnd      in   one-cycle pulse at the first blanked line of a frame
//   cfgValid      in   host write request
//   cfgReady      out  sequencer can accept a write (low during COMMIT)
//   cfgAddr       in   target register (see disp_cfg_pkg register map)
//   cfgData       in   write data; size/offset use only [3:0]
//   charRgbDepth  out  active character colour
//   bkRgbDepth    out  active background colour
//   charSize      out  active character scale
//   charOffset    out  active character offset
//   flashClk      out  blink enable
//   commitPulse   out  one-cycle strobe after the active registers update
// ---------------------------------------------------------------------------
module disp_cfg_sequencer
    import disp_cfg_pkg::*;
#(
    parameter int FLASH_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frameEnd,
    input  logic       cfgValid,
    output logic       cfgReady,
    input  logic [1:0] cfgAddr,
    input  logic [8:0] cfgData,
    output logic [8:0] charRgbDepth,
    output logic [8:0] bkRgbDepth,
    output logic [3:0] charSize,
    output logic [3:0] charOffset,
    output logic       flashClk,
    output logic       commitPulse
);

    // Catch an illegal blink period at elaboration time
    if (FLASH_FRAMES < 1 || FLASH_FRAMES > 255) begin : gBadFlashFrames
        $error("disp_cfg_sequencer: FLASH_FRAMES must be 1..255");
    end

    seqState_t state;
    seqState_t nextState;
    logic      commitEn;
    logic      writeEn;

    logic [8:0] shadowCharRgb;
    logic [8:0] shadowBkRgb;
    logic [3:0] shadowCharSize;
    logic [3:0] shadowCharOffset;
    logic [3:0] dirty;

    // State register; reset is honoured in any state, including COMMIT
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and decode: commit on every frameEnd seen in IDLE even if
    // nothing is dirty, so commitPulse always marks the frame boundary
    always_comb begin
        nextState = state;
        cfgReady  = 1'b0;
        commitEn  = 1'b0;
        case (state)
            IDLE: begin
                cfgReady = 1'b1;
                if (frameEnd) begin
                    nextState = COMMIT;
                end
            end
            COMMIT: begin
                commitEn  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign writeEn = cfgValid && cfgReady;

    // Shadow registers and dirty flags. Writes only happen in IDLE and the
    // dirty clear only in COMMIT, so the two never collide; a write on the
    // same edge as frameEnd lands in the shadow before COMMIT copies it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shadowCharRgb    <= '0;
            shadowBkRgb      <= '0;
            shadowCharSize   <= '0;
            shadowCharOffset <= '0;
            dirty            <= '0;
        end else begin
            if (commitEn) begin
                dirty <= '0;
            end
            if (writeEn) begin
                case (cfgAddr)
                    CFG_CHAR_RGB:    shadowCharRgb    <= cfgData;
                    CFG_BK_RGB:      shadowBkRgb      <= cfgData;
                    CFG_CHAR_SIZE:   shadowCharSize   <= cfgData[3:0];
                    CFG_CHAR_OFFSET: shadowCharOffset <= cfgData[3:0];
                endcase
                dirty[cfgAddr] <= 1'b1;
            end
        end
    end

    // Active display settings: only registers written since the last
    // commit are refreshed, the rest hold their value
    always_ff @(posedge clock) begin
        if (!reset) begin
            charRgbDepth <= CHAR_RGB_RESET;
            bkRgbDepth   <= BK_RGB_RESET;
            charSize     <= CHAR_SIZE_RESET;
            charOffset   <= CHAR_OFFSET_RESET;
            commitPulse  <= 1'b0;
        end else begin
            commitPulse <= commitEn;
            if (commitEn && dirty[CFG_CHAR_RGB]) begin
                charRgbDepth <= shadowCharRgb;
            end
            if (commitEn && dirty[CFG_BK_RGB]) begin
                bkRgbDepth <= shadowBkRgb;
            end
            if (commitEn && dirty[CFG_CHAR_SIZE]) begin
                charSize <= shadowCharSize;
            end
            if (commitEn && dirty[CFG_CHAR_OFFSET]) begin
                charOffset <= shadowCharOffset;
            end
        end
    end

`ifdef DISP_CFG_FLASH_EN
    flash_divider #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) uFlashDivider (
        .clock    (clock),
        .reset    (reset),
        .frameEnd (frameEnd),
        .flashClk (flashClk)
    );
`else
    // Without the divider, characters are simply always shown
    assign flashClk = 1'b1;
`endif

endmodule

// File: tb/tb_disp_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_disp_cfg_sequencer
//
// Directed, table-driven bench for disp_cfg_sequencer (FLASH_FRAMES = 3).
// Each table row is one or more clock cycles of identical inputs followed
// by a check of every output. flashClk expectations come from a small frame
// counting model; a separate hand-written sequence covers the blink pattern.
// ---------------------------------------------------------------------------
module tb_disp_cfg_sequencer;

`ifdef DISP_CFG_FLASH_EN
    localparam bit FlashBuilt = 1'b1;
`else
    localparam bit FlashBuilt = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       frameEnd;
    logic       cfgValid;
    logic       cfgReady;
    logic [1:0] cfgAddr;
    logic [8:0] cfgData;
    logic [8:0] charRgbDepth;
    logic [8:0] bkRgbDepth;
    logic [3:0] charSize;
    logic [3:0] charOffset;
    logic       flashClk;
    logic       commitPulse;

    typedef struct {
        logic       rst;
        logic       fe;
        logic       valid;
        logic [1:0] addr;
        logic [8:0] data;
        int         reps;
        logic [8:0] expChar;
        logic [8:0] expBk;
        logic [3:0] expSize;
        logic [3:0] expOff;
        logic       expPulse;
        logic       expReady;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference blink model: counts frameEnd pulses seen out of reset
    int   modelCnt   = 0;
    logic modelFlash = 1'b0;

    disp_cfg_sequencer #(
        .FLASH_FRAMES (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frameEnd     (frameEnd),
        .cfgValid     (cfgValid),
        .cfgReady     (cfgReady),
        .cfgAddr      (cfgAddr),
        .cfgData      (cfgData),
        .charRgbDepth (charRgbDepth),
        .bkRgbDepth   (bkRgbDepth),
        .charSize     (charSize),
        .charOffset   (charOffset),
        .flashClk     (flashClk),
        .commitPulse  (commitPulse)
    );

    // Free-running 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic fe, input logic valid,
                                input logic [1:0] addr, input logic [8:0] data, input int reps,
                                input logic [8:0] expChar, input logic [8:0] expBk,
                                input logic [3:0] expSize, input logic [3:0] expOff,
                                input logic expPulse, input logic expReady);
        vec_t v;
        v.rst = rst; v.fe = fe; v.valid = valid; v.addr = addr; v.data = data; v.reps = reps;
        v.expChar = expChar; v.expBk = expBk; v.expSize = expSize; v.expOff = expOff;
        v.expPulse = expPulse; v.expReady = expReady;
        return v;
    endfunction

    task automatic checkField(input int row, input string what,
                              input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL row%0d %s: got %h expected %h", row, what, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then advance the blink model
    task automatic applyStimulus(input logic rst, input logic fe, input logic valid,
                                 input logic [1:0] addr, input logic [8:0] data);
        reset    = rst;
        frameEnd = fe;
        cfgValid = valid;
        cfgAddr  = addr;
        cfgData  = data;
        @(posedge clock);
        #1;
        if (!rst) begin
            modelCnt   = 0;
            modelFlash = 1'b0;
        end else if (fe) begin
            if (modelCnt == 2) begin
                modelCnt   = 0;
                modelFlash = ~modelFlash;
            end else begin
                modelCnt++;
            end
        end
    endtask

    task automatic checkOutput(input int row, input vec_t v);
        checkField(row, "charRgbDepth", charRgbDepth, v.expChar);
        checkField(row, "bkRgbDepth", bkRgbDepth, 9'(v.expBk));
        checkField(row, "charSize", 9'(charSize), 9'(v.expSize));
        checkField(row, "charOffset", 9'(charOffset), 9'(v.expOff));
        checkField(row, "commitPulse", 9'(commitPulse), 9'(v.expPulse));
        checkField(row, "cfgReady", 9'(cfgReady), 9'(v.expReady));
        checkField(row, "flashClk", 9'(flashClk), FlashBuilt ? 9'(modelFlash) : 9'h001);
    endtask

    initial begin
        logic [6:0] flashSeq;
        reset    = 1'b0;
        frameEnd = 1'b0;
        cfgValid = 1'b0;
        cfgAddr  = 2'd0;
        cfgData  = 9'h000;

        //         rst fe  v  addr  data  reps  char    bk      sz     off    pls  rdy
        // Reset held for 3 cycles
        vecs.push_back(mk(0, 0, 0, 2'd0, 9'h000, 3, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 1));
        // Deferred commit: two writes, then a long wait with no frameEnd
        vecs.push_back(mk(1, 0, 1, 2'd0, 9'h0A5, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 2'd3, 9'h1F7, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 100, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 2'd0, 9'h000, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h000, 4'h1, 4'h7, 1, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h000, 4'h1, 4'h7, 0, 1));
        // Write on the frameEnd edge is committed; write held through COMMIT stalls
        vecs.push_back(mk(1, 1, 1, 2'd2, 9'h003, 1, 9'h0A5, 9'h000, 4'h1, 4'h7, 0, 0));
        vecs.push_back(mk(1, 0, 1, 2'd2, 9'h00C, 1, 9'h0A5, 9'h000, 4'h3, 4'h7, 1, 1));
        vecs.push_back(mk(1, 0, 1, 2'd2, 9'h00C, 1, 9'h0A5, 9'h000, 4'h3, 4'h7, 0, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 5, 9'h0A5, 9'h000, 4'h3, 4'h7, 0, 1));
        vecs.push_back(mk(1, 1, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h000, 4'h3, 4'h7, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h000, 4'hC, 4'h7, 1, 1));
        // Overwrite before commit: last write wins
        vecs.push_back(mk(1, 0, 1, 2'd1, 9'h011, 1, 9'h0A5, 9'h000, 4'hC, 4'h7, 0, 1));
        vecs.push_back(mk(1, 0, 1, 2'd1, 9'h022, 1, 9'h0A5, 9'h000, 4'hC, 4'h7, 0, 1));
        vecs.push_back(mk(1, 1, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h000, 4'hC, 4'h7, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 1, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 0, 1));
        // Empty commit still pulses
        vecs.push_back(mk(1, 1, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 1, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 0, 1));
        // Reset during COMMIT discards dirty writes
        vecs.push_back(mk(1, 0, 1, 2'd0, 9'h123, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 0, 1));
        vecs.push_back(mk(1, 0, 1, 2'd2, 9'h00F, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 0, 1));
        vecs.push_back(mk(1, 1, 0, 2'd0, 9'h000, 1, 9'h0A5, 9'h022, 4'hC, 4'h7, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 9'h000, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 2'd0, 9'h000, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 9'h000, 1, 9'h1FF, 9'h000, 4'h1, 4'h0, 0, 1));

        $display("[TB] applying %0d table rows", vecs.size());
        for (int row = 0; row < vecs.size(); row++) begin
            for (int r = 0; r < vecs[row].reps; r++) begin
                applyStimulus(vecs[row].rst, vecs[row].fe, vecs[row].valid,
                              vecs[row].addr, vecs[row].data);
                checkOutput(row, vecs[row]);
            end
        end

        // Blink sequence: flashClk after each of 7 frameEnd pulses with
        // FLASH_FRAMES = 3 (bit k is the level after pulse k+1)
        flashSeq = 7'b0011100;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 9'h000);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 9'h000);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 9'h000);
        checkField(100, "flashClk after reset", 9'(flashClk), FlashBuilt ? 9'h000 : 9'h001);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 9'h000);
            checkField(101 + k, "flashClk after frameEnd", 9'(flashClk),
                       FlashBuilt ? 9'(flashSeq[k]) : 9'h001);
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 9'h000);
            checkField(101 + k, "commitPulse in blink run", 9'(commitPulse), 9'h001);
            repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 9'h000);
            checkField(101 + k, "flashClk held", 9'(flashClk),
                       FlashBuilt ? 9'(flashSeq[k]) : 9'h001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_cfg_sequencer.md
# disp_cfg_sequencer

Frame-synchronous configuration sequencer for the character display path. It accepts host writes of colour, character-size and character-offset settings through a valid/ready port and holds them in shadow registers. It commits them to the display controller's configuration inputs only at the start of vertical blanking, so no frame is drawn with mixed settings. It also generates the frame-counted `flashClk` used for blinking characters.

## Interface
- `FLASH_FRAMES`, default 30: frames per `flashClk` half-period. Legal range 1..255.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low reset.
- `frameEnd`  in  1  one-cycle pulse from display timing at first blanked line of each frame.
- `cfgValid`  in  1  host write request.
- `cfgReady`  out  1  sequencer can accept a write.
- `cfgAddr`  in  2  target register: 0 charRgbDepth, 1 bkRgbDepth, 2 charSize, 3 charOffset.
- `cfgData`  in  9  write data. Addresses 2/3 use `[3:0]`; `[8:4]` is ignored.
- `charRgbDepth`  out  9  active character colour.
- `bkRgbDepth`  out  9  active background colour.
- `charSize`  out  4  active character scale.
- `charOffset`  out  4  active character offset.
- `flashClk`  out  1  blink enable.
- `commitPulse`  out  1  one-cycle strobe after active registers are updated.

## Operation
- Write handshake: a transfer occurs on a rising edge where `cfgValid && cfgReady`.
  - `cfgData` goes to `shadow[cfgAddr]` and `dirty[cfgAddr]` is set.
  - If the same address is written again before a commit, the last write wins.
- FSM states:
  - IDLE: `cfgReady`=1.
    - `frameEnd`=1 → COMMIT, regardless of `dirty`.
  - COMMIT (exactly 1 cycle): `cfgReady`=0.
    - For each set `dirty` bit, active register <= shadow and the dirty bit is cleared. Registers whose dirty bit is clear keep their value.
    - → IDLE; `commitPulse` is registered high for the next cycle.
- Simultaneous write and `frameEnd` in IDLE: the write is accepted and is included in that commit.
- `frameEnd` during COMMIT: ignored. It cannot occur legally; frames are far longer than 2 cycles.
- Flash counter:
  - `frameCnt` increments on each `frameEnd` and wraps at `FLASH_FRAMES-1` → 0.
  - On the wrap, `flashClk` toggles.
  - With `FLASH_FRAMES`=1, `flashClk` toggles every frame.
- Reset (synchronous, `reset`=0, honoured mid-operation including in COMMIT):
  - state IDLE, shadow and dirty cleared, `frameCnt`=0.
  - `charRgbDepth`=9'h1FF, `bkRgbDepth`=9'h000, `charSize`=4'd1, `charOffset`=4'd0.
  - `flashClk`=0, `commitPulse`=0.
  - `cfgReady`=1 from the first cycle after reset deasserts.

## Timing
- `frameEnd` sampled high at edge E0 → COMMIT during cycle E0..E1.
- Active outputs take new values after E1.
- `commitPulse` is high E1..E2.
- `cfgReady` is low E0..E1 only.
- Write-to-visible latency: unbounded, until the next `frameEnd`, plus 2 cycles.
- `flashClk` toggles after the edge sampling the `frameEnd` that wraps `frameCnt`.
- All outputs are registered; there is no combinational input-to-output path except `cfgReady` from state.

## Configuration
- `DISP_CFG_FLASH_EN` defined: frame counter and `flashClk` toggle logic are built as described.
- Undefined:
  - No counter is instantiated and `flashClk` is a constant 1'b1, so characters are always shown.
  - `FLASH_FRAMES` is unused.
  - Commit behaviour is unchanged.

## Structure
- `disp_cfg_pkg` holds:
  - address constants `CFG_CHAR_RGB`=0, `CFG_BK_RGB`=1, `CFG_CHAR_SIZE`=2, `CFG_CHAR_OFFSET`=3;
  - the reset-value constants above;
  - the FSM state encoding (IDLE, COMMIT).
- One sub-module, `flash_divider` (frame counter plus toggle), instantiated only under `DISP_CFG_FLASH_EN`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, release → outputs 1FF/000/1/0, `flashClk`=0, `cfgReady`=1, `commitPulse`=0.
- Deferred commit: write addr0=9'h0A5 and addr3=4'h7, no `frameEnd` for 100 cycles → outputs unchanged. Pulse `frameEnd` at E0 → `charRgbDepth`=0A5 and `charOffset`=7 after E1; `commitPulse` high 1 cycle; `bkRgbDepth`/`charSize` unchanged.
- Same-cycle write with `frameEnd`: addr2=4'h3 → `charSize`=3 after E1. `cfgValid` held during COMMIT stalls (`cfgReady`=0); the write is accepted the next cycle and not committed until the following `frameEnd`.
- Overwrite: write addr1=9'h011 then addr1=9'h022, then `frameEnd` → `bkRgbDepth`=022. A second `frameEnd` with no writes → no change, `commitPulse` still pulses.
- Flash (`FLASH_FRAMES`=3, macro defined): 7 `frameEnd` pulses → `flashClk` toggles after pulses 3 and 6, ending at 0. Macro undefined → `flashClk`=1 throughout.
- Mid-commit reset: assert `reset`=0 in the COMMIT cycle after dirty writes → all outputs at reset values, `dirty` cleared; the next `frameEnd` commits nothing.
